// File: rtl/p_shfrot_seq.sv
// Multi-cycle packed shift/rotate unit (32-bit datapath, lanes 32/16/8/4/2) behind valid/ready handshakes.
// Optional macro P_SHFROT_SEQ_LOG_EN selects log-step mode (fixed 5 RUN cycles) instead of 1-bit linear steps.
module p_shfrot_seq (
    input  logic        clock,
    input  logic        reset,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [31:0] crs1,
    input  logic [4:0]  shamt,
    input  logic [4:0]  pw,
    input  logic        shift,
    input  logic        rotate,
    input  logic        left,
    input  logic        right,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] result
);

    // state  | meaning
    // S_IDLE | waiting for a request, op_ready high
    // S_RUN  | stepping the lanes until the step counter reaches 0
    // S_DONE | result held, rsp_valid high until rsp_ready
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [31:0] r_data;
    logic [4:0]  r_lane_m;
    logic        r_shift;
    logic        r_left;
    logic        r_op_ready;
    logic        r_rsp_valid;
`ifdef P_SHFROT_SEQ_LOG_EN
    logic [4:0]  r_amt;
`endif

    logic [4:0]  w_lane_m;
    logic        w_ok;
    logic [4:0]  w_n;
    logic [5:0]  w_step;
    logic [31:0] w_next;

    // Bit i set when its in-lane position (or mirrored position) is below s.
    function automatic logic [31:0] pos_mask(input logic [4:0] m, input logic [5:0] s,
                                             input logic rev);
        logic [31:0] r;
        logic [4:0]  p;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            p    = rev ? (~i[4:0] & m) : (i[4:0] & m);
            r[i] = ({1'b0, p} < s);
        end
        return r;
    endfunction

    function automatic logic [31:0] lane_step(input logic [31:0] d, input logic [4:0] m,
                                              input logic [5:0] s, input logic sh,
                                              input logic lf);
        logic [5:0]  w;
        logic [31:0] lo;
        logic [31:0] hi;
        w  = {1'b0, m} + 6'd1;
        lo = pos_mask(m, s, 1'b0);
        hi = pos_mask(m, s, 1'b1);
        if (lf)
            return ((d << s) & ~lo) | (sh ? 32'd0 : ((d >> (w - s)) & lo));
        else
            return ((d >> s) & ~hi) | (sh ? 32'd0 : ((d << (w - s)) & hi));
    endfunction

    always_comb begin
        w_lane_m = 5'd0;
        casez (pw)
            5'b1????: w_lane_m = 5'd1;
            5'b01???: w_lane_m = 5'd3;
            5'b001??: w_lane_m = 5'd7;
            5'b0001?: w_lane_m = 5'd15;
            5'b00001: w_lane_m = 5'd31;
            default:  w_lane_m = 5'd0;
        endcase
        w_ok = (pw != 5'd0) && (shift || rotate) && (left || right);
        w_n  = 5'd0;
        if (w_ok) begin
            if (shift)
                w_n = (shamt > w_lane_m) ? (w_lane_m + 5'd1) : shamt;
            else
                w_n = shamt & w_lane_m;
        end
    end

`ifdef P_SHFROT_SEQ_LOG_EN
    // Counter runs 5..1 during steps, so step k = 5 - r_cnt weighs amount bit k.
    assign w_step = {1'b0, r_amt & (5'd1 << (5'd5 - r_cnt))};
`else
    assign w_step = 6'd1;
`endif
    assign w_next = lane_step(r_data, r_lane_m, w_step, r_shift, r_left);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 5'd0;
            r_data      <= 32'd0;
            r_lane_m    <= 5'd0;
            r_shift     <= 1'b0;
            r_left      <= 1'b0;
            r_op_ready  <= 1'b1;
            r_rsp_valid <= 1'b0;
`ifdef P_SHFROT_SEQ_LOG_EN
            r_amt       <= 5'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (op_valid) begin
                        r_state    <= S_RUN;
                        r_op_ready <= 1'b0;
                        r_data     <= w_ok ? crs1 : 32'd0;
                        r_lane_m   <= w_lane_m;
                        r_shift    <= shift;
                        r_left     <= left;
`ifdef P_SHFROT_SEQ_LOG_EN
                        r_amt      <= w_n;
                        r_cnt      <= 5'd5;
`else
                        r_cnt      <= w_n;
`endif
                    end
                end
                S_RUN: begin
                    if (r_cnt == 5'd0) begin
                        r_state     <= S_DONE;
                        r_rsp_valid <= 1'b1;
                    end else begin
                        r_data <= w_next;
                        r_cnt  <= r_cnt - 5'd1;
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        r_state     <= S_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_op_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_op_ready  <= 1'b1;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign op_ready  = r_op_ready;
    assign rsp_valid = r_rsp_valid;
    assign result    = r_data;

endmodule

// File: tb/tb_p_shfrot_seq.sv
// Randomized self-checking bench for p_shfrot_seq against a per-lane arithmetic reference model.
module tb_p_shfrot_seq;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [31:0] crs1 = '0;
    logic [4:0]  shamt = '0;
    logic [4:0]  pw = '0;
    logic        shift = 1'b0, rotate = 1'b0, left = 1'b0, right = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    p_shfrot_seq dut (
        .clock(clock), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .crs1(crs1), .shamt(shamt), .pw(pw), .shift(shift), .rotate(rotate),
        .left(left), .right(right), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .result(result)
    );

    always #5 clock = ~clock;

    function automatic int lane_w(input logic [4:0] p);
        if (p[4]) return 2;
        if (p[3]) return 4;
        if (p[2]) return 8;
        if (p[1]) return 16;
        if (p[0]) return 32;
        return 0;
    endfunction

    function automatic logic [31:0] model(input logic [31:0] a, input logic [4:0] sa,
                                          input logic [4:0] p, input logic s, input logic r,
                                          input logic l, input logic rt);
        int W;
        int amt;
        longint unsigned mask, v, o, acc;
        W = lane_w(p);
        if (W == 0 || !(s || r) || !(l || rt)) return 32'd0;
        mask = (64'd1 << W) - 64'd1;
        acc  = 0;
        for (int ln = 0; ln < 32 / W; ln++) begin
            v = ({32'd0, a} >> (ln * W)) & mask;
            if (s) begin
                if (int'(sa) >= W) o = 0;
                else o = l ? ((v << sa) & mask) : (v >> sa);
            end else begin
                amt = int'(sa) % W;
                o = l ? (((v << amt) | (v >> (W - amt))) & mask)
                      : (((v >> amt) | (v << (W - amt))) & mask);
            end
            acc = acc | (o << (ln * W));
        end
        return acc[31:0];
    endfunction

    function automatic int model_lat(input logic [4:0] sa, input logic [4:0] p, input logic s,
                                     input logic r, input logic l, input logic rt);
        int W;
        int n;
`ifdef P_SHFROT_SEQ_LOG_EN
        return 6;
`else
        W = lane_w(p);
        if (W == 0 || !(s || r) || !(l || rt)) n = 0;
        else if (s) n = (int'(sa) < W) ? int'(sa) : W;
        else n = int'(sa) % W;
        return n + 1;
`endif
    endfunction

    // Issue one request and wait (bounded) for rsp_valid; inputs are scrambled after accept.
    task automatic run_op(input logic [31:0] a, input logic [4:0] sa, input logic [4:0] p,
                          input logic s, input logic r, input logic l, input logic rt,
                          output logic [31:0] res, output int lat, output bit to);
        @(negedge clock);
        crs1 = a; shamt = sa; pw = p; shift = s; rotate = r; left = l; right = rt;
        op_valid = 1'b1;
        @(posedge clock); #1;
        op_valid = 1'b0;
        crs1 = $urandom; shamt = 5'($urandom); pw = 5'($urandom);
        shift = 1'($urandom); rotate = 1'($urandom); left = 1'($urandom); right = 1'($urandom);
        lat = 0;
        while (!rsp_valid && lat < 200) begin
            @(posedge clock); #1;
            lat++;
        end
        to  = !rsp_valid;
        res = result;
    endtask

    task automatic ack();
        @(negedge clock);
        rsp_ready = 1'b1;
        @(posedge clock); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic check_op(input string name, input logic [31:0] a, input logic [4:0] sa,
                            input logic [4:0] p, input logic s, input logic r, input logic l,
                            input logic rt);
        logic [31:0] res, exp_r;
        int lat, exp_l;
        bit to;
        exp_r = model(a, sa, p, s, r, l, rt);
        exp_l = model_lat(sa, p, s, r, l, rt);
        run_op(a, sa, p, s, r, l, rt, res, lat, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL %s timeout: rsp_valid never rose", name);
        end else begin
            checks++;
            if (res !== exp_r) begin
                errors++;
                $display("FAIL %s result: got %h expected %h", name, res, exp_r);
            end
            if (lat !== exp_l) begin
                errors++;
                $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_l);
            end
        end
        ack();
    endtask

    task automatic test_reset();
        checks++;
        if (op_ready !== 1'b1 || rsp_valid !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("FAIL reset: op_ready=%b rsp_valid=%b result=%h expected 1 0 0",
                     op_ready, rsp_valid, result);
        end
    endtask

    task automatic test_directed();
        check_op("vec1_shl32", 32'h0000_0001, 5'd31, 5'b00001, 1, 0, 1, 0);
        check_op("vec2_ror16", 32'h0001_8001, 5'd17, 5'b00010, 0, 1, 0, 1);
        check_op("vec3_shr8_sat", 32'hFFFF_FFFF, 5'd8, 5'b00100, 1, 0, 0, 1);
        check_op("vec4_rol2", 32'h5555_5555, 5'd3, 5'b10000, 0, 1, 1, 0);
        check_op("pw_zero", 32'hDEAD_BEEF, 5'd3, 5'b00000, 1, 0, 1, 0);
        check_op("no_op", 32'hDEAD_BEEF, 5'd3, 5'b00001, 0, 0, 1, 0);
        check_op("no_dir", 32'hDEAD_BEEF, 5'd3, 5'b00001, 0, 1, 0, 0);
        check_op("prio_pw", 32'h1234_5678, 5'd1, 5'b11111, 0, 1, 1, 0);
        check_op("prio_op_dir", 32'h8765_4321, 5'd2, 5'b00100, 1, 1, 1, 1);
        check_op("shamt0", 32'hCAFE_F00D, 5'd0, 5'b01000, 0, 1, 0, 1);
    endtask

    task automatic test_random();
        logic [4:0] p;
        for (int i = 0; i < 60; i++) begin
            p = (i % 3 == 0) ? 5'($urandom) : (5'd1 << $urandom_range(0, 4));
            check_op("random", $urandom, 5'($urandom), p, 1'($urandom), 1'($urandom),
                     1'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] res, held, exp_r;
        int lat;
        bit to;
        exp_r = model(32'h0F0F_1234, 5'd5, 5'b00010, 0, 1, 1, 0);
        run_op(32'h0F0F_1234, 5'd5, 5'b00010, 0, 1, 1, 0, res, lat, to);
        held = res;
        checks++;
        if (to || held !== exp_r) begin
            errors++;
            $display("FAIL bp_result: got %h expected %h (timeout=%0d)", held, exp_r, to);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            op_valid = 1'b1;
            checks++;
            if (rsp_valid !== 1'b1 || result !== held || op_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: rsp_valid=%b result=%h op_ready=%b expected 1 %h 0",
                         c, rsp_valid, result, op_ready, held);
            end
        end
        op_valid = 1'b0;
        ack();
        checks++;
        if (op_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: op_ready=%b rsp_valid=%b expected 1 0", op_ready, rsp_valid);
        end
    endtask

    task automatic test_back_to_back();
        check_op("b2b_a", 32'hA5A5_5A5A, 5'd7, 5'b00100, 0, 1, 0, 1);
        check_op("b2b_b", 32'h0123_4567, 5'd13, 5'b00001, 1, 0, 0, 1);
        check_op("b2b_c", 32'hFFFF_0000, 5'd16, 5'b00010, 1, 0, 1, 0);
    endtask

    task automatic test_reset_mid();
        @(negedge clock);
        crs1 = 32'hFFFF_FFFF; shamt = 5'd30; pw = 5'b00001;
        shift = 1'b0; rotate = 1'b1; left = 1'b1; right = 1'b0;
        op_valid = 1'b1;
        @(posedge clock); #1;
        op_valid = 1'b0;
        repeat (3) @(posedge clock);
        #3 reset = 1'b1;
        #1;
        checks++;
        if (op_ready !== 1'b1 || rsp_valid !== 1'b0 || result !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid: op_ready=%b rsp_valid=%b result=%h expected 1 0 0",
                     op_ready, rsp_valid, result);
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (40) begin
            @(posedge clock); #1;
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid_no_rsp: rsp_valid=%b expected 0", rsp_valid);
            end
        end
        check_op("after_reset", 32'h8000_0001, 5'd1, 5'b00001, 0, 1, 0, 1);
    endtask

    initial begin
        repeat (2) @(negedge clock);
        test_reset();
        reset = 1'b0;
        @(negedge clock);
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
